// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: datapath width and FSM states.
package fetch_unit_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    F_RESET  = 2'd0,
    F_RUN    = 2'd1,
    F_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_queue.sv
// Prefetch FIFO: synchronous push/pop/flush, head presented combinationally from storage.
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;

  // Storage is cleared on reset so the head word reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign count     = cnt;
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential requests, prefetch queue,
// redirect flush with discard of stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     WIDTH    = fetch_unit_pkg::WIDTH,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             halt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e     state, state_nxt;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] head_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop;
  logic [CW-1:0]    q_count;
  logic [WIDTH-1:0] q_head;
  logic [CW:0]      inflight;
  logic             req_fire;
  logic             push;
  logic             pop;

  always_comb begin
    state_nxt = state;
    case (state)
      F_RESET:  state_nxt = F_RUN;
      F_RUN:    if (halt) state_nxt = F_HALTED;
      F_HALTED: if (!halt) state_nxt = F_RUN;
      default:  state_nxt = F_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= F_RESET;
    else        state <= state_nxt;
  end

  // Credit counts words already queued plus words still owed by memory, including
  // ones that will be dropped, so a push can never find the queue full.
  assign inflight       = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = reset && (state == F_RUN) && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop == '0) && !redirect;
  assign pop            = inst_valid && inst_ready && !redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        fetch_pc <= redirect_target;
        head_pc  <= redirect_target;
        drop     <= drop + outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + WIDTH'(1);
        if (pop)      head_pc  <= head_pc + WIDTH'(1);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (imem_rsp_data),
    .pop       (pop),
    .flush     (redirect),
    .count     (q_count),
    .head_data (q_head)
  );

  assign inst_valid = (q_count != '0);
  assign inst       = q_head;
  assign inst_pc    = head_pc;

endmodule
